// File: rtl/timer_irq_peripheral.sv
// Memory-mapped reload timer with sticky overflow status and registered IRQ.
// Optional free-running SYSTICK counter at +0x14 when TIMER_SYSTICK_EN is defined.
module timer_irq_peripheral #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        irq
);

  localparam int unsigned PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(PRESCALE - 1);

  localparam logic [2:0] IDX_TH   = 3'd0;
  localparam logic [2:0] IDX_TL   = 3'd1;
  localparam logic [2:0] IDX_TCON = 3'd2;
  localparam logic [2:0] IDX_STK  = 3'd5;

  logic [31:0]   th_q, th_d;
  logic [31:0]   tl_q, tl_d;
  logic [2:0]    tcon_q, tcon_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          irq_q, irq_d;
  logic [31:0]   systick;

  logic [31:0] off;
  logic [2:0]  idx;
  logic        wr_en;
  logic        we_th, we_tl, we_tcon;
  logic        tick;

  // Address window decode; the compare spans all offset bits
  always_comb begin
    off     = addr - BASE_ADDR;
    sel     = (off < 32'd32);
    idx     = off[4:2];
    wr_en   = mem_write && sel;
    we_th   = wr_en && (idx == IDX_TH);
    we_tl   = wr_en && (idx == IDX_TL);
    we_tcon = wr_en && (idx == IDX_TCON);
  end

  // Zero-latency read mux of pre-edge register state
  always_comb begin
    rdata = 32'd0;
    if (mem_read && sel) begin
      unique case (idx)
        IDX_TH:   rdata = th_q;
        IDX_TL:   rdata = tl_q;
        IDX_TCON: rdata = {29'd0, tcon_q};
        IDX_STK:  rdata = systick;
        default:  rdata = 32'd0;
      endcase
    end
  end

  // Prescaler, count/reload and bus-write priority
  always_comb begin
    tick   = tcon_q[0] && (pre_q == PRE_TC);
    pre_d  = pre_q;
    th_d   = we_th ? wdata : th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    if (tcon_q[0]) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
    end
    if (tick) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d = th_q;
        if (tcon_q[1]) tcon_d[2] = 1'b1;
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end
    if (we_tl)   tl_d   = wdata;
    if (we_tcon) tcon_d = wdata[2:0];
    irq_d = tcon_q[2] & tcon_q[1];
  end

  // Timer state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q   <= 32'd0;
      tl_q   <= 32'd0;
      tcon_q <= 3'd0;
      pre_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      pre_q  <= pre_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;

`ifdef TIMER_SYSTICK_EN
  logic [31:0] systick_q, systick_d;

  // Free-running tick counter, wraps naturally
  always_comb begin
    systick_d = systick_q + 32'd1;
  end

  // SYSTICK register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) systick_q <= 32'd0;
    else        systick_q <= systick_d;
  end

  assign systick = systick_q;
`else
  assign systick = 32'd0;
`endif

endmodule

// File: tb/tb_timer_irq_peripheral.sv
// Scoreboard bench for timer_irq_peripheral.
// Expected values are queued with stimulus and popped at sampling.
module tb_timer_irq_peripheral;

  localparam logic [31:0] B   = 32'h4000_0000;
  localparam logic [31:0] ATH = B;
  localparam logic [31:0] ATL = B + 32'h4;
  localparam logic [31:0] ATC = B + 32'h8;
  localparam logic [31:0] AST = B + 32'h14;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        sel;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];

  timer_irq_peripheral #(
    .BASE_ADDR(B),
    .PRESCALE (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .wdata    (wdata),
    .rdata    (rdata),
    .sel      (sel),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag,
                          input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq(e.tag, obs, e.exp);
    end
  endtask

  task automatic rd_now(input logic [31:0] a,
                        input logic [31:0] exp,
                        input string tag);
    addr     = a;
    mem_read = 1'b1;
    sb_push(tag, exp);
    #1;
    sb_pop(rdata);
    mem_read = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a,
                    input logic [31:0] exp,
                    input string tag);
    @(negedge clk);
    rd_now(a, exp, tag);
  endtask

  task automatic sel_now(input logic [31:0] a,
                         input logic exp,
                         input string tag);
    addr = a;
    sb_push(tag, {31'd0, exp});
    #1;
    sb_pop({31'd0, sel});
  endtask

  task automatic irq_now(input logic exp, input string tag);
    sb_push(tag, {31'd0, exp});
    sb_pop({31'd0, irq});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr      = a;
    wdata     = d;
    mem_write = 1'b1;
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v1;
    logic [31:0] v2;
    reset     = 1'b0;
    addr      = 32'd0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    wdata     = 32'd0;
    #2;
    rd_now(ATC, 32'd0, "rst_tcon");
    irq_now(1'b0, "rst_irq");
    @(negedge clk);
    reset = 1'b1;

    // Reset mid-count
    wr(ATL, 32'd5);
    wr(ATC, 32'd7);
    @(negedge clk);
    irq_now(1'b1, "pre_rst_irq");
    #2;
    reset = 1'b0;
    #1;
    irq_now(1'b0, "async_irq");
    rd_now(ATL, 32'd0, "async_tl");
    rd_now(ATH, 32'd0, "async_th");
    rd_now(ATC, 32'd0, "async_tcon");
    @(negedge clk);
    reset = 1'b1;

    // Overflow and reload
    wr(ATH, 32'hFFFF_FFF0);
    wr(ATL, 32'hFFFF_FFFE);
    wr(ATC, 32'd3);
    rd(ATL, 32'hFFFF_FFFF, "ovf_tl_max");
    rd(ATL, 32'hFFFF_FFF0, "ovf_reload");
    rd_now(ATC, 32'd7, "ovf_tcon");
    irq_now(1'b0, "ovf_irq_lag");
    @(negedge clk);
    irq_now(1'b1, "ovf_irq");
    rd_now(ATL, 32'hFFFF_FFF1, "ovf_cnt");

    // Software clear
    wr(ATC, 32'd3);
    irq_now(1'b1, "clr_irq_hold");
    @(negedge clk);
    irq_now(1'b0, "clr_irq");
    rd_now(ATL, 32'hFFFF_FFF4, "clr_cnt");

    // Disable holds TL
    wr(ATC, 32'd0);
    wr(ATL, 32'd7);
    repeat (20) @(negedge clk);
    rd_now(ATL, 32'd7, "dis_tl");
    irq_now(1'b0, "dis_irq");

    // irq_enable off through overflow
    wr(ATH, 32'h100);
    wr(ATL, 32'hFFFF_FFFE);
    wr(ATC, 32'd1);
    rd(ATL, 32'hFFFF_FFFF, "noie_max");
    rd(ATL, 32'h100, "noie_reload");
    rd_now(ATC, 32'd1, "noie_tcon");
    @(negedge clk);
    irq_now(1'b0, "noie_irq");

    // TL write wins over reload
    wr(ATC, 32'd0);
    wr(ATH, 32'h200);
    wr(ATL, 32'hFFFF_FFFE);
    wr(ATC, 32'd3);
    wr(ATL, 32'h10);
    rd_now(ATL, 32'h10, "col_tl");

    // TCON write wins over status set
    wr(ATC, 32'd0);
    wr(ATL, 32'hFFFF_FFFE);
    wr(ATC, 32'd3);
    wr(ATC, 32'd3);
    rd_now(ATC, 32'd3, "col_tcon");
    rd_now(ATL, 32'h200, "col_tcon_tl");
    @(negedge clk);
    irq_now(1'b0, "col_irq0");
    @(negedge clk);
    irq_now(1'b0, "col_irq1");

    // Bus decode
    wr(ATC, 32'd0);
    rd(B + 32'hC, 32'd0, "hole_0c");
    rd_now(B - 32'd4, 32'd0, "oow_rdata");
    sel_now(B - 32'd4, 1'b0, "oow_sel");
    sel_now(B + 32'h1C, 1'b1, "top_sel");
    sel_now(B + 32'h20, 1'b0, "past_sel");
    wr(B + 32'h24, 32'hDEAD_BEEF);
    wr(B - 32'd4, 32'hDEAD_BEEF);
    rd(ATH, 32'h200, "oow_wr_th");
    rd_now(B + 32'h2, 32'h200, "unalign_th");

    // Simultaneous read and write
    @(negedge clk);
    addr      = ATH;
    wdata     = 32'h55;
    mem_write = 1'b1;
    rd_now(ATH, 32'h200, "rw_prewrite");
    @(negedge clk);
    mem_write = 1'b0;
    rd_now(ATH, 32'h55, "rw_post");

    // SYSTICK
`ifdef TIMER_SYSTICK_EN
    @(negedge clk);
    addr     = AST;
    mem_read = 1'b1;
    #1;
    v1 = rdata;
    mem_read = 1'b0;
    repeat (10) @(negedge clk);
    addr     = AST;
    mem_read = 1'b1;
    #1;
    v2 = rdata;
    mem_read = 1'b0;
    sb_push("stk_diff", 32'd10);
    sb_pop(v2 - v1);
`else
    v1 = 32'd0;
    v2 = 32'd0;
    rd(AST, v1 | v2, "stk_absent");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
